mem_wb_skid: RTL and testbench
==============================

# mem_wb_skid

Parametrised MEM/WB pipeline stage that carries load data, ALU result and up to NUM_WR register write-back channels from the memory stage to the write-back stage. It replaces a plain edge register with a valid/ready handshake backed by a 2-entry skid buffer. It also provides synchronous flush and same-address write-conflict resolution, so downstream back-pressure never drops or duplicates an instruction.

## Interface
Parameters:
- DATA_W, 16, width of every data value
- RADDR_W, 4, register-file address width
- NUM_WR, 2, number of write-back channels (channel 0 = op1 destination, channel 1 = R15)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- flush  in  1  synchronous kill of all held entries
- in_valid  in  1  upstream entry present
- in_ready  out  1  stage can accept an entry this cycle
- in_mem_data  in  DATA_W  memory read data
- in_alu  in  DATA_W  ALU result
- in_wdata  in  NUM_WR*DATA_W  write value per channel, channel i at bits [i*DATA_W +: DATA_W]
- in_waddr  in  NUM_WR*RADDR_W  destination register per channel
- in_wen  in  NUM_WR  write enable per channel
- out_valid  out  1  output entry present
- out_ready  in  1  write-back stage consumes the entry
- out_mem_data, out_alu  out  DATA_W  registered copies
- out_wdata  out  NUM_WR*DATA_W  registered copies
- out_waddr  out  NUM_WR*RADDR_W  registered copies
- out_wen  out  NUM_WR  registered write enables ANDed with out_valid
- occupancy  out  2  number of valid entries held (0..2)

## Operation
- Storage has two entry registers: OUT, which drives the out_* ports, and SKID. Each entry holds all data fields plus the wen vector.
- State machine:
  - EMPTY: nothing held.
  - ONE: OUT valid, SKID empty.
  - FULL: both valid.
- in_ready = (state != FULL). It is combinational from state only and is never derived from out_ready.
- Transfers: accept = in_valid & in_ready; consume = out_valid & out_ready.
- EMPTY: on accept, load OUT and go to ONE. Otherwise stay.
- ONE:
  - accept & consume: load OUT from the input, stay ONE.
  - consume only: go to EMPTY.
  - accept only: load SKID, go to FULL.
  - neither: hold.
- FULL: on consume, OUT <= SKID and go to ONE. Otherwise hold. No accept is possible in FULL.
- Flush has the highest priority. State goes to EMPTY, and an accept or consume in the same cycle is discarded. Data registers need not clear, but out_wen reads 0 because it is masked by out_valid.
- Write-conflict rule, applied at capture: when channels i < j have equal waddr and both wen set, channel i's stored wen is cleared. The highest index wins, so an R15 write overrides an op1 write to R15.
- occupancy: EMPTY=0, ONE=1, FULL=2.
- Order is preserved. Each accepted entry appears on the output exactly once unless it is flushed.

## Timing
- Reset (asynchronous, rst low):
  - State goes to EMPTY.
  - All entry data, waddr and wen registers clear to 0.
  - Outputs: out_valid=0, out_wen=0, occupancy=0, in_ready=1, all out data 0.
- Reset mid-operation discards both entries immediately, without waiting for a clock edge.
- Latency from the EMPTY state: an entry accepted at edge N is visible on out_* after edge N, with out_valid=1.
- Throughput is one entry per cycle while out_ready stays high. SKID stays unused in that case.
- Out_* registers are all updated by the same clock edge. No output depends combinationally on any in_* port.
- After one cycle of out_ready=0 with in_valid=1, in_ready drops in the following cycle. The second entry is captured in SKID and lost nowhere.
- Simultaneous flush and rst: rst dominates. The result is the same in both cases.

## Test plan
- Reset, then stream 4 entries (alu=0x0001..0x0004, ch0 waddr=3 wen=1) with out_ready=1. Required: outputs follow one cycle later in order, occupancy stays ≤1, in_ready stays 1.
- Back-pressure: hold out_ready=0 while presenting A=0x00AA then B=0x00BB. Required:
  - occupancy reaches 2 and in_ready=0.
  - A is held on the output.
  - On release of out_ready, A then B appear on consecutive cycles with no loss or duplicate.
- Flush in FULL with in_valid=1: next cycle out_valid=0, occupancy=0, out_wen=0, in_ready=1. The flushed-cycle input never appears.
- Conflict: ch0 waddr=15 wen=1 wdata=0x1111, ch1 waddr=15 wen=1 wdata=0x2222. Required: out_wen=2'b10. With different addresses, out_wen=2'b11.
- Assert rst asynchronously mid-cycle while FULL. Required: outputs clear before the next clk edge, and the first entry after reset has one-cycle latency.
- Random in_valid/out_ready/flush for 10k cycles against a scoreboard queue. Required: order is preserved, occupancy matches the queue depth, and in_ready=0 only when occupancy=2.

Source files
------------

// File: rtl/mem_wb_skid.sv
// MEM/WB pipeline stage with a valid/ready handshake over a two-entry skid buffer.
// Same-address write-back conflicts are resolved when an entry is captured, and the highest channel wins.
module mem_wb_skid #(
    parameter int DATA_W  = 16,
    parameter int RADDR_W = 4,
    parameter int NUM_WR  = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [DATA_W-1:0]          in_mem_data,
    input  logic [DATA_W-1:0]          in_alu,
    input  logic [NUM_WR*DATA_W-1:0]   in_wdata,
    input  logic [NUM_WR*RADDR_W-1:0]  in_waddr,
    input  logic [NUM_WR-1:0]          in_wen,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DATA_W-1:0]          out_mem_data,
    output logic [DATA_W-1:0]          out_alu,
    output logic [NUM_WR*DATA_W-1:0]   out_wdata,
    output logic [NUM_WR*RADDR_W-1:0]  out_waddr,
    output logic [NUM_WR-1:0]          out_wen,
    output logic [1:0]                 occupancy
);

    localparam int WD_W    = NUM_WR * DATA_W;
    localparam int WA_W    = NUM_WR * RADDR_W;
    localparam int ENTRY_W = 2 * DATA_W + WD_W + WA_W + NUM_WR;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    // A lower channel loses its enable whenever a higher enabled channel targets the same register.
    function automatic logic [NUM_WR-1:0] resolve_wen(
        input logic [NUM_WR-1:0] wen,
        input logic [WA_W-1:0]   waddr
    );
        logic [NUM_WR-1:0] res;
        res = wen;
        for (int i = 0; i < NUM_WR; i++) begin
            for (int j = i + 1; j < NUM_WR; j++) begin
                if (wen[i] && wen[j] &&
                    (waddr[i*RADDR_W +: RADDR_W] == waddr[j*RADDR_W +: RADDR_W])) begin
                    res[i] = 1'b0;
                end else begin
                    res[i] = res[i];
                end
            end
        end
        return res;
    endfunction

    state_t               state_r;
    state_t               state_s;
    logic [ENTRY_W-1:0]   out_entry_r;
    logic [ENTRY_W-1:0]   skid_entry_r;
    logic [ENTRY_W-1:0]   in_entry_s;
    logic [NUM_WR-1:0]    out_wen_raw_s;
    logic                 accept_s;
    logic                 consume_s;
    logic                 load_out_in_s;
    logic                 load_out_skid_s;
    logic                 load_skid_s;

    assign in_ready   = (state_r != ST_FULL);
    assign out_valid  = (state_r != ST_EMPTY);
    assign accept_s   = in_valid & in_ready;
    assign consume_s  = out_valid & out_ready;
    assign in_entry_s = {in_mem_data, in_alu, in_wdata, in_waddr, resolve_wen(in_wen, in_waddr)};

    assign {out_mem_data, out_alu, out_wdata, out_waddr, out_wen_raw_s} = out_entry_r;
    assign out_wen = out_wen_raw_s & {NUM_WR{out_valid}};

    // Next-state and entry-load decode; flush overrides any transfer in the same cycle.
    always_comb begin
        state_s         = state_r;
        load_out_in_s   = 1'b0;
        load_out_skid_s = 1'b0;
        load_skid_s     = 1'b0;
        if (flush) begin
            state_s = ST_EMPTY;
        end else begin
            case (state_r)
                ST_EMPTY: begin
                    if (accept_s) begin
                        load_out_in_s = 1'b1;
                        state_s       = ST_ONE;
                    end else begin
                        state_s = ST_EMPTY;
                    end
                end
                ST_ONE: begin
                    if (accept_s && consume_s) begin
                        load_out_in_s = 1'b1;
                        state_s       = ST_ONE;
                    end else if (consume_s) begin
                        state_s = ST_EMPTY;
                    end else if (accept_s) begin
                        load_skid_s = 1'b1;
                        state_s     = ST_FULL;
                    end else begin
                        state_s = ST_ONE;
                    end
                end
                ST_FULL: begin
                    if (consume_s) begin
                        load_out_skid_s = 1'b1;
                        state_s         = ST_ONE;
                    end else begin
                        state_s = ST_FULL;
                    end
                end
                default: state_s = ST_EMPTY;
            endcase
        end
    end

    // Occupancy follows directly from the state encoding.
    always_comb begin
        case (state_r)
            ST_EMPTY: occupancy = 2'd0;
            ST_ONE:   occupancy = 2'd1;
            ST_FULL:  occupancy = 2'd2;
            default:  occupancy = 2'd0;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_EMPTY;
        end else begin
            state_r <= state_s;
        end
    end

    // Entry registers: OUT is loaded from the input or promoted from SKID.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_entry_r  <= {ENTRY_W{1'b0}};
            skid_entry_r <= {ENTRY_W{1'b0}};
        end else begin
            if (load_out_in_s) begin
                out_entry_r <= in_entry_s;
            end else if (load_out_skid_s) begin
                out_entry_r <= skid_entry_r;
            end else begin
                out_entry_r <= out_entry_r;
            end
            if (load_skid_s) begin
                skid_entry_r <= in_entry_s;
            end else begin
                skid_entry_r <= skid_entry_r;
            end
        end
    end

endmodule

// File: tb/tb_mem_wb_skid.sv
// Scoreboard bench for mem_wb_skid: accepted entries are queued with their expected
// write enables and compared, in order, against the output whenever it is valid.
module tb_mem_wb_skid;

    typedef struct {
        logic [15:0] mem;
        logic [15:0] alu;
        logic [31:0] wdata;
        logic [7:0]  waddr;
        logic [1:0]  wen;
    } ent_t;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_mem_data;
    logic [15:0] in_alu;
    logic [31:0] in_wdata;
    logic [7:0]  in_waddr;
    logic [1:0]  in_wen;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_mem_data;
    logic [15:0] out_alu;
    logic [31:0] out_wdata;
    logic [7:0]  out_waddr;
    logic [1:0]  out_wen;
    logic [1:0]  occupancy;

    int   n_checks;
    int   n_errors;
    ent_t sb_q[$];

    mem_wb_skid #(.DATA_W(16), .RADDR_W(4), .NUM_WR(2)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_mem_data(in_mem_data), .in_alu(in_alu), .in_wdata(in_wdata),
        .in_waddr(in_waddr), .in_wen(in_wen),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_mem_data(out_mem_data), .out_alu(out_alu), .out_wdata(out_wdata),
        .out_waddr(out_waddr), .out_wen(out_wen), .occupancy(occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [1:0] exp_wen(input logic [1:0] wen, input logic [7:0] waddr);
        if (wen == 2'b11 && waddr[3:0] == waddr[7:4]) return 2'b10;
        else return wen;
    endfunction

    // Compare DUT outputs against the scoreboard head (called away from the rising edge).
    task automatic check_state();
        int depth;
        depth = sb_q.size();
        check_val("out_valid", 64'(out_valid), 64'(depth > 0));
        check_val("occupancy", 64'(occupancy), 64'(depth));
        check_val("in_ready", 64'(in_ready), 64'(depth < 2));
        if (depth > 0) begin
            check_val("out_mem_data", 64'(out_mem_data), 64'(sb_q[0].mem));
            check_val("out_alu", 64'(out_alu), 64'(sb_q[0].alu));
            check_val("out_wdata", 64'(out_wdata), 64'(sb_q[0].wdata));
            check_val("out_waddr", 64'(out_waddr), 64'(sb_q[0].waddr));
            check_val("out_wen", 64'(out_wen), 64'(sb_q[0].wen));
        end else begin
            check_val("out_wen_empty", 64'(out_wen), 64'd0);
        end
    endtask

    // One clock cycle: drive inputs, check at the falling edge, update the model at the rising edge.
    task automatic drive_cycle(input logic iv, input logic ordy, input logic fl,
                               input logic [15:0] alu, input logic [15:0] mem,
                               input logic [31:0] wdata, input logic [7:0] waddr,
                               input logic [1:0] wen);
        bit   acc;
        bit   con;
        ent_t e;
        in_valid    = iv;
        out_ready   = ordy;
        flush       = fl;
        in_alu      = alu;
        in_mem_data = mem;
        in_wdata    = wdata;
        in_waddr    = waddr;
        in_wen      = wen;
        @(negedge clk);
        check_state();
        acc = iv && (sb_q.size() < 2);
        con = ordy && (sb_q.size() > 0);
        @(posedge clk);
        if (fl) begin
            sb_q.delete();
        end else begin
            if (con) void'(sb_q.pop_front());
            if (acc) begin
                e.mem = mem; e.alu = alu; e.wdata = wdata; e.waddr = waddr;
                e.wen = exp_wen(wen, waddr);
                sb_q.push_back(e);
            end
        end
        #1;
    endtask

    task automatic simple(input logic iv, input logic ordy, input logic fl, input logic [15:0] alu);
        drive_cycle(iv, ordy, fl, alu, alu ^ 16'h5A5A, {alu, ~alu}, 8'h03, 2'b01);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_mem_data = 16'd0; in_alu = 16'd0; in_wdata = 32'd0; in_waddr = 8'd0; in_wen = 2'd0;

        #3;
        check_state();
        check_val("rst_alu", 64'(out_alu), 64'd0);
        check_val("rst_mem", 64'(out_mem_data), 64'd0);
        check_val("rst_wdata", 64'(out_wdata), 64'd0);
        check_val("rst_waddr", 64'(out_waddr), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Streaming with out_ready high: one-cycle latency, occupancy never above one.
        for (int i = 1; i <= 4; i++) simple(1'b1, 1'b1, 1'b0, 16'(i));
        simple(1'b0, 1'b1, 1'b0, 16'd0);
        simple(1'b0, 1'b1, 1'b0, 16'd0);

        // Back-pressure: A then B fill both entries, C is refused while full.
        simple(1'b1, 1'b0, 1'b0, 16'h00AA);
        simple(1'b1, 1'b0, 1'b0, 16'h00BB);
        simple(1'b1, 1'b0, 1'b0, 16'h00CC);
        check_val("bp_full_occ", 64'(occupancy), 64'd2);
        simple(1'b0, 1'b1, 1'b0, 16'd0);
        simple(1'b0, 1'b1, 1'b0, 16'd0);
        simple(1'b0, 1'b1, 1'b0, 16'd0);

        // Flush while full with a valid input in the same cycle.
        simple(1'b1, 1'b0, 1'b0, 16'h0011);
        simple(1'b1, 1'b0, 1'b0, 16'h0022);
        simple(1'b1, 1'b1, 1'b1, 16'h0033);
        simple(1'b0, 1'b1, 1'b0, 16'd0);

        // Write conflicts: same address keeps only channel 1; distinct addresses keep both.
        drive_cycle(1'b1, 1'b1, 1'b0, 16'h0100, 16'h0200, {16'h2222, 16'h1111}, 8'hFF, 2'b11);
        drive_cycle(1'b1, 1'b1, 1'b0, 16'h0101, 16'h0201, {16'h2222, 16'h1111}, 8'hF3, 2'b11);
        drive_cycle(1'b0, 1'b1, 1'b0, 16'h0000, 16'h0000, 32'd0, 8'h00, 2'b00);
        drive_cycle(1'b1, 1'b0, 1'b0, 16'h0102, 16'h0202, {16'h2222, 16'h1111}, 8'hFF, 2'b11);
        check_val("conflict_wen", 64'(out_wen), 64'(2'b10));
        simple(1'b0, 1'b1, 1'b0, 16'd0);

        // Asynchronous reset while full clears outputs before the next edge.
        simple(1'b1, 1'b0, 1'b0, 16'h0044);
        simple(1'b1, 1'b0, 1'b0, 16'h0055);
        #2;
        rst = 1'b0;
        in_valid = 1'b0;
        #1;
        sb_q.delete();
        check_val("arst_valid", 64'(out_valid), 64'd0);
        check_val("arst_occ", 64'(occupancy), 64'd0);
        check_val("arst_ready", 64'(in_ready), 64'd1);
        check_val("arst_alu", 64'(out_alu), 64'd0);
        check_val("arst_wen", 64'(out_wen), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        simple(1'b1, 1'b1, 1'b0, 16'h0066);
        simple(1'b0, 1'b1, 1'b0, 16'd0);

        // Random traffic against the scoreboard.
        for (int c = 0; c < 10000; c++) begin
            drive_cycle(1'($urandom_range(0, 1)),
                        1'($urandom_range(0, 2) != 0),
                        1'($urandom_range(0, 31) == 0),
                        16'($urandom), 16'($urandom), $urandom,
                        {4'($urandom_range(13, 15)), 4'($urandom_range(13, 15))},
                        2'($urandom_range(0, 3)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
